// File: rtl/timer_irq_arb.sv
// -----------------------------------------------------------------------------
// timer_irq_arb
//   Collects the level interrupt lines of a timer, turns rising edges into
//   latched pending flags (with sticky overflow on missed events), and presents
//   one enabled pending source at a time to the CPU using round-robin
//   arbitration. A presented request is held until acknowledged, or withdrawn
//   when its pending flag is cleared or its enable bit is removed. Every
//   acknowledge is followed by a single idle gap cycle.
//
// Ports
//   clk       in   1          single clock, all state on rising edge
//   rst       in   1          synchronous active-high reset
//   src_irq   in   NSRC       level interrupt lines from the timer
//   mask_we   in   1          write strobe for the enable mask
//   mask_in   in   NSRC       enable mask data, 1 = enabled
//   clr_we    in   1          write strobe for software clear
//   clr_in    in   NSRC       bits to clear in pending and overflow
//   irq_ack   in   1          CPU acknowledge of the presented interrupt
//   irq       out  1          interrupt request to the CPU (registered)
//   irq_id    out  IDW        index of the presented source (registered)
//   pending   out  NSRC       latched pending flags
//   overflow  out  NSRC       sticky missed-event flags
//   mask      out  NSRC       current enable mask
// -----------------------------------------------------------------------------
module timer_irq_arb #(
    parameter int NSRC = 4,
    parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_in,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_in,
    input  logic            irq_ack,
    output logic            irq,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] overflow,
    output logic [NSRC-1:0] mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [NSRC-1:0] r_src_q;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_overflow;
    logic [NSRC-1:0] r_mask;
    logic            r_irq;
    logic [IDW-1:0]  r_irq_id;
    logic [IDW-1:0]  r_last_grant;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_ack_vec;
    logic [NSRC-1:0] w_pending_next;
    logic [NSRC-1:0] w_overflow_next;
    logic [NSRC-1:0] w_mask_next;
    logic [NSRC-1:0] w_req;
    logic            w_ack;
    logic            w_withdraw;
    logic            w_load_id;
    logic [IDW-1:0]  w_winner;
    logic [IDW-1:0]  w_idx;

    // Event detection and next values of the flag registers.
    always_comb begin
        w_edge    = src_irq & ~r_src_q;
        w_clr     = {NSRC{clr_we}} & clr_in;
        w_ack     = (r_state == ST_REQ) & irq_ack;
        w_ack_vec = w_ack ? ({{(NSRC-1){1'b0}}, 1'b1} << r_irq_id) : {NSRC{1'b0}};
        // A new edge wins over both a software clear and an acknowledge.
        w_pending_next  = w_edge | (r_pending & ~w_clr & ~w_ack_vec);
        // A clear also suppresses the overflow an edge would otherwise set.
        w_overflow_next = (r_overflow | (w_edge & r_pending)) & ~w_clr;
        w_mask_next     = mask_we ? mask_in : r_mask;
        w_req           = r_pending & r_mask;
        // Withdraw when the presented source loses its pending flag or enable;
        // only consulted when no acknowledge is present.
        w_withdraw = ~w_pending_next[r_irq_id] | ~w_mask_next[r_irq_id];
    end

    // Round-robin winner: lowest offset from last_grant+1 with a request.
    // Iterating from the farthest offset down leaves the nearest hit in w_winner.
    always_comb begin
        w_winner = {IDW{1'b0}};
        w_idx    = {IDW{1'b0}};
        for (int k = NSRC; k >= 1; k--) begin
            w_idx    = IDW'((int'(r_last_grant) + k) % NSRC);
            w_winner = w_req[w_idx] ? w_idx : w_winner;
        end
    end

    // Presentation FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_load_id    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_next = ST_REQ;
                    w_load_id    = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_state_next = ST_GAP;
                end else if (w_withdraw) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Source sampling, pending/overflow flags and enable mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_q    <= {NSRC{1'b0}};
            r_pending  <= {NSRC{1'b0}};
            r_overflow <= {NSRC{1'b0}};
            r_mask     <= {NSRC{1'b0}};
        end else begin
            r_src_q    <= src_irq;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            r_mask     <= w_mask_next;
        end
    end

    // FSM state, registered request outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_irq_id     <= {IDW{1'b0}};
            r_last_grant <= IDW'(NSRC - 1);
        end else begin
            r_state <= w_state_next;
            r_irq   <= (w_state_next == ST_REQ);
            if (w_load_id) begin
                r_irq_id <= w_winner;
            end
            if (w_ack) begin
                r_last_grant <= r_irq_id;
            end
        end
    end

    assign irq      = r_irq;
    assign irq_id   = r_irq_id;
    assign pending  = r_pending;
    assign overflow = r_overflow;
    assign mask     = r_mask;

endmodule
